lvds_s2p: RTL and testbench

//  Receive-side deserializer for the LVDS serial link: the 1-bit-per-clock stream
//  {vld,2'b0,bit} from the far-end transmitter is packed MSB-first into bytes and
//  re-framed with sof/vld/eof plus a byte length. Sits between LVDS capture and
//  the byte-wide frame processing/FIFO path.

---
 rtl/lvds_link_pkg.sv | 18 +
 rtl/lvds_s2p_shift.sv | 48 ++++
 rtl/lvds_s2p.sv | 242 ++++++++++++++++++++++++
 tb/tb_lvds_s2p.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS serial link receive path.
//   VLD_BIT / DAT_BIT : field positions inside the 4-bit serial symbol
//   state_t           : deserializer FSM encoding
//   LEN_W / CNT_W     : frame length and frame counter widths
package lvds_link_pkg;

  localparam int VLD_BIT = 3;
  localparam int DAT_BIT = 0;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/lvds_s2p_shift.sv
// MSB-first 8-bit shifter with bit counter.
//   clk, rst_n  : clock, async active-low reset
//   shift_en    : append bit_in to the byte being assembled
//   load_en     : start a fresh byte with bit_in as its first bit
//   clr_en      : discard the partial byte
//   bit_in      : serial data bit
//   bit_cnt     : bits currently held (0..7)
//   byte_done   : this cycle's shift completes a byte (byte_val is valid)
//   byte_val    : completed byte, first bit in [7]
//   pad_val     : partial byte left-aligned, LSBs zero
module lvds_s2p_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       load_en,
  input  logic       clr_en,
  input  logic       bit_in,
  output logic [2:0] bit_cnt,
  output logic       byte_done,
  output logic [7:0] byte_val,
  output logic [7:0] pad_val
);

  // Only 7 bits need storing; the 8th arrives on bit_in as the byte completes.
  logic [6:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load_en) begin
      sr      <= {6'b0, bit_in};
      bit_cnt <= 3'd1;
    end else if (clr_en) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= {sr[5:0], bit_in};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign byte_val  = {sr, bit_in};
  // Held bits sit in sr[bit_cnt-1:0]; move the oldest one up to bit 7.
  assign pad_val   = {sr, 1'b0} << (3'd7 - bit_cnt);

endmodule

// File: rtl/lvds_s2p.sv
// LVDS receive deserializer: packs the 1-bit-per-clock stream MSB-first into
// bytes and re-frames them with sof/vld/eof, byte length and error flag.
//   clk, rst_n            : clock, async active-low reset
//   din, din_vld, din_sof : serial symbol (data in din[0]), bit strobe, frame start
//   dout, dout_vld        : packed byte, one-cycle strobe
//   dout_sof, dout_eof    : first / last byte of frame (qualified by dout_vld)
//   dout_len, dout_err    : frame length in bytes and error flag (with dout_eof)
//   cnt_frame_rx          : delivered frames, wrapping
//   cnt_err               : errored + dropped frames, saturating
//
// state | meaning
// IDLE  | waiting for the first bit of a frame
// RECV  | shifting frame bits, one completed byte held as lookahead
// FLUSH | emitting a padded tail; may already be receiving the next frame
module lvds_s2p
  import lvds_link_pkg::*;
#(
  parameter int MAX_BYTES = 4096,
  parameter int GAP_MIN   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       din,
  input  logic             din_vld,
  input  logic             din_sof,
  output logic [7:0]       dout,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic [LEN_W-1:0] dout_len,
  output logic             dout_err,
  output logic [CNT_W-1:0] cnt_frame_rx,
  output logic [15:0]      cnt_err
);

  state_t state, state_nxt;

  logic             shift_en, load_en, clr_en;
  logic [2:0]       bit_cnt;
  logic             byte_done;
  logic [7:0]       byte_val, pad_val;

  logic             start, cap_drop, end_frm, mk_pend, drop;
  logic             nf;
  logic [7:0]       hold;
  logic             hold_full;
  logic             first;
  logic             err_r;
  logic [LEN_W-1:0] byte_cnt;
  logic             at_cap;

  logic             pend_vld;
  logic [7:0]       pend_byte;
  logic             pend_sof;
  logic [LEN_W-1:0] pend_len;

  logic             emit_vld, emit_sof, emit_eof, emit_err;
  logic [7:0]       emit_byte;
  logic [LEN_W-1:0] emit_len;
  logic             err_inc;

  // The marker and spare symbol bits carry nothing the strobe does not.
  logic unused_din;
  assign unused_din = ^{din[VLD_BIT], din[2:1]};

  assign at_cap = (byte_cnt == LEN_W'(MAX_BYTES));

  lvds_s2p_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .load_en   (load_en),
    .clr_en    (clr_en),
    .bit_in    (din[DAT_BIT]),
    .bit_cnt   (bit_cnt),
    .byte_done (byte_done),
    .byte_val  (byte_val),
    .pad_val   (pad_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (din_vld) state_nxt = ST_RECV;
      ST_RECV:  if (!din_vld || din_sof) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = (nf || (din_vld && din_sof)) ? ST_RECV : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    load_en  = 1'b0;
    clr_en   = 1'b0;
    start    = 1'b0;
    cap_drop = 1'b0;
    end_frm  = 1'b0;
    mk_pend  = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (din_vld) begin
          start   = 1'b1;
          load_en = 1'b1;
        end
      end
      ST_RECV: begin
        if (din_vld && !din_sof) begin
          if (at_cap) cap_drop = 1'b1;
          else        shift_en = 1'b1;
        end else begin
          end_frm = 1'b1;
          mk_pend = (bit_cnt != 3'd0);
          // The partial tail is captured into pend this cycle, so the
          // shifter is free to take the next frame's first bit.
          if (din_vld) begin
            start   = 1'b1;
            load_en = 1'b1;
          end else begin
            clr_en  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (din_vld) begin
          if (nf) begin
            shift_en = 1'b1;
          end else if (din_sof) begin
            start   = 1'b1;
            load_en = 1'b1;
          end else begin
            // A stray strobe here only breaks protocol when upstream
            // promised an idle gap between frames.
            drop = (GAP_MIN > 0);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    emit_vld  = 1'b0;
    emit_byte = '0;
    emit_sof  = 1'b0;
    emit_eof  = 1'b0;
    emit_len  = '0;
    emit_err  = 1'b0;
    if (state == ST_FLUSH) begin
      if (pend_vld) begin
        emit_vld  = 1'b1;
        emit_byte = pend_byte;
        emit_sof  = pend_sof;
        emit_eof  = 1'b1;
        emit_len  = pend_len;
        emit_err  = 1'b1;
      end
    end else if (hold_full && (byte_done || end_frm)) begin
      emit_vld  = 1'b1;
      emit_byte = hold;
      emit_sof  = first;
      if (end_frm && !mk_pend) begin
        emit_eof = 1'b1;
        emit_len = byte_cnt;
        emit_err = err_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nf        <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      first     <= 1'b0;
      err_r     <= 1'b0;
      byte_cnt  <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      pend_sof  <= 1'b0;
      pend_len  <= '0;
    end else begin
      // Marks a FLUSH whose strobes already belong to the next frame.
      nf <= start && (state == ST_RECV);

      if (start) begin
        first     <= 1'b1;
        err_r     <= !din_sof;
        byte_cnt  <= '0;
        hold_full <= 1'b0;
      end else begin
        if (byte_done) begin
          hold      <= byte_val;
          hold_full <= 1'b1;
          byte_cnt  <= byte_cnt + 1'b1;
          if (hold_full) first <= 1'b0;
        end
        if (cap_drop) err_r     <= 1'b1;
        if (end_frm)  hold_full <= 1'b0;
      end

      if (mk_pend) begin
        pend_vld  <= 1'b1;
        pend_byte <= pad_val;
        pend_sof  <= first && !hold_full;
        pend_len  <= byte_cnt + 1'b1;
      end else if (state == ST_FLUSH) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  assign err_inc = (emit_vld && emit_eof && emit_err) || drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= '0;
      dout_vld     <= 1'b0;
      dout_sof     <= 1'b0;
      dout_eof     <= 1'b0;
      dout_len     <= '0;
      dout_err     <= 1'b0;
      cnt_frame_rx <= '0;
      cnt_err      <= '0;
    end else begin
      dout     <= emit_byte;
      dout_vld <= emit_vld;
      dout_sof <= emit_sof;
      dout_eof <= emit_eof;
      dout_len <= emit_len;
      dout_err <= emit_err;
      if (emit_vld && emit_eof) cnt_frame_rx <= cnt_frame_rx + 1'b1;
      if (err_inc && (cnt_err != 16'hFFFF)) cnt_err <= cnt_err + 16'd1;
    end
  end

endmodule

// File: tb/tb_lvds_s2p.sv
module tb_lvds_s2p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  din = 4'h0;
  logic        din_vld = 1'b0;
  logic        din_sof = 1'b0;
  logic [7:0]  dout;
  logic        dout_vld, dout_sof, dout_eof, dout_err;
  logic [15:0] dout_len;
  logic [31:0] cnt_frame_rx;
  logic [15:0] cnt_err;

  typedef logic [26:0] rec_t;   // {byte, sof, eof, len, err}
  rec_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int stray = 0;

  always #5 clk = ~clk;

  lvds_s2p #(.MAX_BYTES(4), .GAP_MIN(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_vld      (din_vld),
    .din_sof      (din_sof),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .dout_sof     (dout_sof),
    .dout_eof     (dout_eof),
    .dout_len     (dout_len),
    .dout_err     (dout_err),
    .cnt_frame_rx (cnt_frame_rx),
    .cnt_err      (cnt_err)
  );

  always @(posedge clk) begin
    #1;
    if (dout_vld) q.push_back({dout, dout_sof, dout_eof, dout_len, dout_err});
    else if (dout_sof || dout_eof || dout_err || (dout_len != 16'd0)) stray++;
  end

  task automatic send_bits(input logic [63:0] bits, input int n, input bit with_sof);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_vld = 1'b1;
      din_sof = with_sof && (i == 0);
      din     = {1'b1, 2'b00, bits[n-1-i]};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_vld = 1'b0;
      din_sof = 1'b0;
      din     = 4'h0;
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic sof, input logic eof,
                             input logic [15:0] len, input logic err, input string tag);
    rec_t obs, exp;
    exp = {b, sof, eof, len, err};
    if (q.size() == 0) obs = 'x;
    else               obs = q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle(3);
    check_val({24'd0, dout_vld, dout_sof, dout_eof, dout_err, 4'd0}, 32'd0, "reset_flags");
    check_val({16'd0, dout_len}, 32'd0, "reset_len");
    check_val(cnt_frame_rx, 32'd0, "reset_frames");
    check_val({16'd0, cnt_err}, 32'd0, "reset_errs");
    rst_n = 1'b1;
    idle(2);

    // 3-byte frame
    send_bits(64'hA53CFF, 24, 1'b1);
    idle(4);
    expect_byte(8'hA5, 1'b1, 1'b0, 16'd0, 1'b0, "t1_b0");
    expect_byte(8'h3C, 1'b0, 1'b0, 16'd0, 1'b0, "t1_b1");
    expect_byte(8'hFF, 1'b0, 1'b1, 16'd3, 1'b0, "t1_b2");
    check_val(q.size(), 32'd0, "t1_extra");
    check_val(cnt_frame_rx, 32'd1, "t1_frames");
    check_val({16'd0, cnt_err}, 32'd0, "t1_errs");

    // 1-byte frame
    send_bits(64'h81, 8, 1'b1);
    idle(4);
    expect_byte(8'h81, 1'b1, 1'b1, 16'd1, 1'b0, "t2_b0");
    check_val(cnt_frame_rx, 32'd2, "t2_frames");

    // 12 bits: one full byte plus padded tail
    send_bits(64'hAAF, 12, 1'b1);
    idle(4);
    expect_byte(8'hAA, 1'b1, 1'b0, 16'd0, 1'b0, "t3_b0");
    expect_byte(8'hF0, 1'b0, 1'b1, 16'd2, 1'b1, "t3_b1");
    check_val(cnt_frame_rx, 32'd3, "t3_frames");
    check_val({16'd0, cnt_err}, 32'd1, "t3_errs");

    // 5-bit frame: single padded byte
    send_bits(64'h16, 5, 1'b1);
    idle(4);
    expect_byte(8'hB0, 1'b1, 1'b1, 16'd1, 1'b1, "t3b_b0");
    check_val({16'd0, cnt_err}, 32'd2, "t3b_errs");

    // first bit without din_sof
    send_bits(64'hC3, 8, 1'b0);
    idle(4);
    expect_byte(8'hC3, 1'b1, 1'b1, 16'd1, 1'b1, "t3c_b0");
    check_val(cnt_frame_rx, 32'd5, "t3c_frames");
    check_val({16'd0, cnt_err}, 32'd3, "t3c_errs");

    // back-to-back frames, strobe held high across the boundary
    send_bits(64'h1234, 16, 1'b1);
    send_bits(64'hABCD, 16, 1'b1);
    idle(4);
    expect_byte(8'h12, 1'b1, 1'b0, 16'd0, 1'b0, "t4_f0_b0");
    expect_byte(8'h34, 1'b0, 1'b1, 16'd2, 1'b0, "t4_f0_b1");
    expect_byte(8'hAB, 1'b1, 1'b0, 16'd0, 1'b0, "t4_f1_b0");
    expect_byte(8'hCD, 1'b0, 1'b1, 16'd2, 1'b0, "t4_f1_b1");
    check_val(cnt_frame_rx, 32'd7, "t4_frames");
    check_val({16'd0, cnt_err}, 32'd3, "t4_errs");

    // 6-byte frame against MAX_BYTES=4
    send_bits(64'h112233445566, 48, 1'b1);
    idle(4);
    expect_byte(8'h11, 1'b1, 1'b0, 16'd0, 1'b0, "t5_b0");
    expect_byte(8'h22, 1'b0, 1'b0, 16'd0, 1'b0, "t5_b1");
    expect_byte(8'h33, 1'b0, 1'b0, 16'd0, 1'b0, "t5_b2");
    expect_byte(8'h44, 1'b0, 1'b1, 16'd4, 1'b1, "t5_b3");
    check_val(q.size(), 32'd0, "t5_extra");
    check_val(cnt_frame_rx, 32'd8, "t5_frames");
    check_val({16'd0, cnt_err}, 32'd4, "t5_errs");

    // reset in the middle of a frame
    send_bits(64'h0F0F, 13, 1'b1);
    @(negedge clk);
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sof = 1'b0;
    din     = 4'h0;
    idle(2);
    check_val({24'd0, dout_vld, dout_sof, dout_eof, dout_err, 4'd0}, 32'd0, "t6_rst_flags");
    check_val(cnt_frame_rx, 32'd0, "t6_rst_frames");
    check_val({16'd0, cnt_err}, 32'd0, "t6_rst_errs");
    rst_n = 1'b1;
    idle(3);
    check_val(q.size(), 32'd0, "t6_no_eof");
    send_bits(64'h5A, 8, 1'b1);
    idle(4);
    expect_byte(8'h5A, 1'b1, 1'b1, 16'd1, 1'b0, "t6_b0");
    check_val(cnt_frame_rx, 32'd1, "t6_frames");
    check_val({16'd0, cnt_err}, 32'd0, "t6_errs");
    check_val(stray, 32'd0, "idle_flags_zero");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
